// File: rtl/bcd_updown_counter_pkg.sv
// ============================================================================
// Module : bcd_updown_counter_pkg
// Brief  : Shared constants for the cascaded BCD up/down counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bcd_updown_counter_pkg;

    localparam int DIGIT_W         = 4;
    localparam int DEFAULT_DIGITS  = 2;
    localparam int DEFAULT_MODULUS = 10;

endpackage : bcd_updown_counter_pkg

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// Module : bcd_digit
// Brief  : One modulo-MODULUS up/down digit with sanitising parallel load.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_digit
    import bcd_updown_counter_pkg::*;
#(
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] d_i,
    input  logic               step,
    input  logic               up,
    output logic [DIGIT_W-1:0] q_i,
    output logic               at_max,
    output logic               at_zero
);

    localparam logic [DIGIT_W:0]   c_MOD = (DIGIT_W+1)'(MODULUS);
    localparam logic [DIGIT_W-1:0] c_MAX = DIGIT_W'(MODULUS - 1);

    logic [DIGIT_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            // Out-of-range load values collapse to 0 so the digit never leaves 0..MODULUS-1.
            r_q <= ({1'b0, d_i} >= c_MOD) ? '0 : d_i;
        end else if (step) begin
            if (up) begin
                r_q <= at_max ? '0 : r_q + DIGIT_W'(1);
            end else begin
                r_q <= at_zero ? c_MAX : r_q - DIGIT_W'(1);
            end
        end
    end

    assign q_i     = r_q;
    assign at_max  = (r_q == c_MAX);
    assign at_zero = (r_q == '0);

endmodule : bcd_digit

`default_nettype wire

// File: rtl/bcd_updown_counter.sv
// ============================================================================
// Module : bcd_updown_counter
// Brief  : DIGITS cascaded up/down digits with terminal count and wrap pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int DIGITS  = DEFAULT_DIGITS,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      up,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] d,
    output logic [DIGIT_W*DIGITS-1:0] q,
    output logic                      tc,
    output logic                      wrap
);

    logic [DIGITS-1:0] w_at_max;
    logic [DIGITS-1:0] w_at_zero;
    logic [DIGITS-1:0] w_step;
    logic [DIGITS:0]   w_carry_up;
    logic [DIGITS:0]   w_carry_dn;
    logic              r_wrap;

    // Bit i is set when every digit below i sits at its rollover value for the current direction.
    always_comb begin
        w_carry_up    = '0;
        w_carry_dn    = '0;
        w_carry_up[0] = 1'b1;
        w_carry_dn[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_carry_up[i+1] = w_carry_up[i] & w_at_max[i];
            w_carry_dn[i+1] = w_carry_dn[i] & w_at_zero[i];
        end
    end

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            assign w_step[i] = en & (up ? w_carry_up[i] : w_carry_dn[i]);

            bcd_digit #(
                .MODULUS (MODULUS)
            ) u_digit (
                .clk     (clk),
                .rst     (rst),
                .load    (load),
                .d_i     (d[DIGIT_W*i +: DIGIT_W]),
                .step    (w_step[i]),
                .up      (up),
                .q_i     (q[DIGIT_W*i +: DIGIT_W]),
                .at_max  (w_at_max[i]),
                .at_zero (w_at_zero[i])
            );
        end
    endgenerate

    assign tc = up ? w_carry_up[DIGITS] : w_carry_dn[DIGITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= en & ~load & tc;
        end
    end

    assign wrap = r_wrap;

endmodule : bcd_updown_counter

`default_nettype wire

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 2: number of cascaded digits, legal range 1..8.
REQ-002 Parameter MODULUS, default 10: count modulus per digit, legal range 2..16.
REQ-003 Signal clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Signal rst, input, 1 bit: the reset is synchronous and active-high.
REQ-005 Signal en, input, 1 bit: count enable.
REQ-006 Signal up, input, 1 bit: direction, 1 = count up, 0 = count down.
REQ-007 Signal load, input, 1 bit: synchronous parallel load strobe.
REQ-008 Signal d, input, 4*DIGITS bits: load value, digit i at bits [4i+3:4i].
REQ-009 Signal q, output, 4*DIGITS bits: registered count, digit i at bits [4i+3:4i], digit 0 least significant.
REQ-010 Signal tc, output, 1 bit: combinational terminal-count flag.
REQ-011 Signal wrap, output, 1 bit: registered one-cycle wrap-around pulse.

Function
REQ-012 Priority per edge SHALL be rst > load > en; with none active, q and wrap SHALL hold and clear respectively.
REQ-013 On load, each digit SHALL take its d field; any field >= MODULUS SHALL be stored as 0. wrap SHALL be 0 that cycle.
REQ-014 When en=1 and up=1, digit 0 SHALL increment every cycle; digit i>0 SHALL increment only when all lower digits equal MODULUS-1.
REQ-015 An incrementing digit at MODULUS-1 SHALL become 0.
REQ-016 When en=1 and up=0, digit 0 SHALL decrement every cycle; digit i>0 SHALL decrement only when all lower digits equal 0.
REQ-017 A decrementing digit at 0 SHALL become MODULUS-1.
REQ-018 tc SHALL be 1 when up=1 and all digits equal MODULUS-1, or when up=0 and all digits equal 0, independent of en.
REQ-019 wrap SHALL be 1 on the cycle after an edge where en=1, load=0, rst=0 and tc=1; otherwise it SHALL be 0.
REQ-020 wrap SHALL therefore coincide with q = all-zero (up) or all-(MODULUS-1) (down).
REQ-021 A direction change SHALL take effect on the same edge it is sampled; there is no latency beyond one clock from input to q.
REQ-022 Digit values SHALL never leave 0..MODULUS-1 under any input sequence after reset.
REQ-023 Unused upper bits of each 4-bit field SHALL be 0 when MODULUS <= 8.

Reset
REQ-024 On a clock edge with rst=1, q SHALL become all zeros and wrap SHALL become 0, overriding load and en.
REQ-025 Reset asserted mid-count SHALL abort counting on that edge; counting SHALL resume from 0 on the first edge with rst=0 and en=1.
REQ-026 tc SHALL reflect the reset state: 0 with up=1, 1 with up=0.

Structure
REQ-027 A shared package SHALL hold DIGIT_W = 4 and the default DIGITS and MODULUS constants.
REQ-028 One sub-module, bcd_digit, SHALL implement a single digit: inputs clk, rst, load, d_i, step, up; outputs q_i, at_max, at_zero.
REQ-029 The top level SHALL instantiate DIGITS copies of bcd_digit in a generate loop.
REQ-030 The top level SHALL form each step from en and the ripple of lower at_max (up) or at_zero (down) flags.
REQ-031 The top level SHALL implement tc and the wrap register.

Verification (DIGITS=2, MODULUS=10)
REQ-032 Apply rst=1 for 2 cycles, then en=1, up=1 for 12 cycles -> q = 0x00 after reset; q steps 01..09, 10, 11, 12; wrap stays 0.
REQ-033 Load 0x98, then en=1, up=1 for 2 cycles -> q = 0x99 with tc=1, then q = 0x00 with wrap=1 for exactly one cycle.
REQ-034 From reset, set en=1, up=0 for 1 cycle -> tc=1 before the edge; after the edge q = 0x99 and wrap=1.
REQ-035 Load d=0xA5 -> q = 0x05, since the invalid upper digit is stored as 0.
REQ-036 Assert load=1 with d=0x42, en=1 and rst=1 in the same cycle -> q = 0x00.
REQ-037 At q = 0x37, set en=0 for 3 cycles -> q holds 0x37 and wrap stays 0.
REQ-038 Count up to 0x09, then switch up=0 -> q = 0x08 on the next edge.
